// File: rtl/lsu_access_pkg.sv
// Shared constants and lane helpers for the load/store access unit.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned-access trap).
package lsu_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    // funct3 size codes (low two bits give log2 of the access size)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [63:0] ZERO_WORD     = 64'd0;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
    localparam logic        WRITE_DISABLE = 1'b0;

    // Clear the low log2(size) bits of the byte offset.
    function automatic logic [2:0] align_offset(input logic [2:0] f3, input logic [2:0] off);
        logic [2:0] r;
        case (f3[1:0])
            2'd0:    r = off;
            2'd1:    r = {off[2:1], 1'b0};
            2'd2:    r = {off[2], 2'b00};
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
        return off != align_offset(f3, off);
    endfunction

endpackage

// File: rtl/lsu_access_align.sv
// lsu_align: combinational byte-lane steering (store mask/shift, load shift/extend).
module lsu_align
    import lsu_access_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] sdata,
    input  logic [XLEN-1:0] rdata,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ldata
);

    logic [5:0]      shamt;
    logic [7:0]      base_mask;
    logic [XLEN-1:0] rsh;

    assign shamt = {offset, 3'b000};

    always_comb begin
        base_mask = 8'hFF;
        case (funct3[1:0])
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        wmask = base_mask << offset;
        wdata = sdata << shamt;
        rsh   = rdata >> shamt;
        ldata = rsh;
        case (funct3)
            F3_B:    ldata = {{(XLEN-8){rsh[7]}}, rsh[7:0]};
            F3_H:    ldata = {{(XLEN-16){rsh[15]}}, rsh[15:0]};
            F3_W:    ldata = {{(XLEN-32){rsh[31]}}, rsh[31:0]};
            F3_BU:   ldata = {{(XLEN-8){1'b0}}, rsh[7:0]};
            F3_HU:   ldata = {{(XLEN-16){1'b0}}, rsh[15:0]};
            F3_WU:   ldata = {{(XLEN-32){1'b0}}, rsh[31:0]};
            default: ldata = rsh;
        endcase
    end

endmodule

// File: rtl/lsu_access.sv
// Load/store access unit: registers execute results and runs the data-memory bus.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned accesses instead of aligning).
module lsu_access
    import lsu_access_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid_i,
    input  logic [4:0]      ex_wd_i,
    input  logic            ex_wreg_i,
    input  logic [XLEN-1:0] ex_wdata_i,
    input  logic            ex_is_load_i,
    input  logic            ex_is_store_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [XLEN-1:0] ex_addr_i,
    input  logic [XLEN-1:0] ex_sdata_i,
    output logic            stall_req_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [7:0]      dmem_wmask_o,
    input  logic            dmem_ready_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            out_valid_o,
    output logic [4:0]      wd_o,
    output logic            wreg_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            misalign_o,
    output logic [1:0]      dbg_state_o
);

    lsu_state_e state, state_nxt;

    logic       accept, is_mem, trap, issue;
    logic [2:0] off_eff;

    logic            lat_store;
    logic [2:0]      lat_f3;
    logic [2:0]      lat_off;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_sdata;
    logic [4:0]      lat_wd;
    logic            lat_wreg;

    logic [7:0]      al_wmask;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_ldata;
    logic            trap_q;

    assign accept = (state == ST_IDLE) && ex_valid_i;
    assign is_mem = ex_is_load_i || ex_is_store_i;

`ifdef LSU_MISALIGN_TRAP_EN
    assign off_eff = ex_addr_i[2:0];
    assign trap    = accept && is_mem && misaligned(ex_funct3_i, ex_addr_i[2:0]);
`else
    assign off_eff = align_offset(ex_funct3_i, ex_addr_i[2:0]);
    assign trap    = 1'b0;
`endif

    assign issue = accept && is_mem && !trap;

    always_ff @(posedge clk) begin
        if (rst_n) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (issue) state_nxt = ST_REQ;
            ST_REQ:  if (dmem_ready_i) state_nxt = lat_store ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (dmem_rvalid_i) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            lat_store <= 1'b0;
            lat_f3    <= 3'b000;
            lat_off   <= 3'b000;
            lat_addr  <= '0;
            lat_sdata <= '0;
            lat_wd    <= NOP_REG_ADDR;
            lat_wreg  <= WRITE_DISABLE;
        end else if (issue) begin
            lat_store <= ex_is_store_i;
            lat_f3    <= ex_funct3_i;
            lat_off   <= off_eff;
            lat_addr  <= {ex_addr_i[XLEN-1:3], 3'b000};
            lat_sdata <= ex_sdata_i;
            lat_wd    <= ex_wd_i;
            lat_wreg  <= ex_wreg_i;
        end
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3 (lat_f3),
        .offset (lat_off),
        .sdata  (lat_sdata),
        .rdata  (dmem_rdata_i),
        .wmask  (al_wmask),
        .wdata  (al_wdata),
        .ldata  (al_ldata)
    );

    // Bus fields come from latched state, so they are stable for the whole REQ phase.
    assign stall_req_o  = (state != ST_IDLE);
    assign dmem_req_o   = (state == ST_REQ);
    assign dmem_we_o    = dmem_req_o && lat_store;
    assign dmem_addr_o  = dmem_req_o ? lat_addr : '0;
    assign dmem_wdata_o = dmem_we_o ? al_wdata : '0;
    assign dmem_wmask_o = dmem_we_o ? al_wmask : 8'h00;
    assign dbg_state_o  = state;
    assign misalign_o   = trap_q;

    always_ff @(posedge clk) begin
        out_valid_o <= 1'b0;
        wd_o        <= NOP_REG_ADDR;
        wreg_o      <= WRITE_DISABLE;
        wdata_o     <= '0;
        trap_q      <= 1'b0;
        if (!rst_n) begin
            if (accept && !is_mem) begin
                out_valid_o <= 1'b1;
                wd_o        <= ex_wd_i;
                wreg_o      <= ex_wreg_i;
                wdata_o     <= ex_wdata_i;
            end else if (trap) begin
                out_valid_o <= 1'b1;
                trap_q      <= 1'b1;
            end else if (state == ST_REQ && dmem_ready_i && lat_store) begin
                out_valid_o <= 1'b1;
            end else if (state == ST_WAIT && dmem_rvalid_i) begin
                out_valid_o <= 1'b1;
                wd_o        <= lat_wd;
                wreg_o      <= lat_wreg;
                wdata_o     <= al_ldata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_access.sv
// Bench for lsu_access: directed vector table, multi-cycle corner sequences, random ops vs. model.
module tb_lsu_access;
    import lsu_access_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_i;
    logic [4:0]  ex_wd_i;
    logic        ex_wreg_i;
    logic [63:0] ex_wdata_i;
    logic        ex_is_load_i;
    logic        ex_is_store_i;
    logic [2:0]  ex_funct3_i;
    logic [63:0] ex_addr_i;
    logic [63:0] ex_sdata_i;
    logic        stall_req_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [63:0] dmem_addr_o;
    logic [63:0] dmem_wdata_o;
    logic [7:0]  dmem_wmask_o;
    logic        dmem_ready_i;
    logic        dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;
    logic        out_valid_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [63:0] wdata_o;
    logic        misalign_o;
    logic [1:0]  dbg_state_o;

    int total = 0;
    int bad   = 0;

    lsu_access #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .ex_wd_i(ex_wd_i),
        .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
        .ex_is_store_i(ex_is_store_i), .ex_funct3_i(ex_funct3_i), .ex_addr_i(ex_addr_i),
        .ex_sdata_i(ex_sdata_i), .stall_req_o(stall_req_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_wmask_o(dmem_wmask_o), .dmem_ready_i(dmem_ready_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .out_valid_o(out_valid_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .misalign_o(misalign_o), .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model, straight from the lane rules
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic int m_off(input logic [63:0] addr, input logic [2:0] f3);
        int o;
        o = int'(addr % 64'd8);
        return (o / m_size(f3)) * m_size(f3);
    endfunction

    function automatic logic m_misaligned(input logic [63:0] addr, input logic [2:0] f3);
        return (addr % 64'(m_size(f3))) != 64'd0;
    endfunction

    function automatic logic [7:0] m_mask(input logic [2:0] f3, input int off);
        int m;
        m = ((1 << m_size(f3)) - 1) << off;
        return 8'(m);
    endfunction

    function automatic logic [63:0] m_store(input logic [63:0] sdata, input int off);
        return sdata << (8 * off);
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [2:0] f3, input int off);
        logic [63:0] v;
        logic [63:0] keep;
        int bits;
        v = rdata >> (8 * off);
        bits = 8 * m_size(f3);
        if (bits < 64) begin
            keep = (64'd1 << bits) - 64'd1;
            v = v & keep;
            if (!f3[2] && v[bits-1]) v = v | ~keep;
        end
        return v;
    endfunction

    // driver tasks
    task automatic drive_ex(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] sdata,
                            input logic [4:0] wd, input logic wreg, input logic [63:0] alu);
        ex_valid_i    = 1'b1;
        ex_is_load_i  = ld;
        ex_is_store_i = st;
        ex_funct3_i   = f3;
        ex_addr_i     = addr;
        ex_sdata_i    = sdata;
        ex_wd_i       = wd;
        ex_wreg_i     = wreg;
        ex_wdata_i    = alu;
    endtask

    task automatic do_alu(input logic [4:0] wd, input logic wreg, input logic [63:0] alu);
        drive_ex(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, wd, wreg, alu);
        tick();
        ex_valid_i = 1'b0;
        check("alu_valid", 64'(out_valid_o), 64'd1);
        check("alu_wd", 64'(wd_o), 64'(wd));
        check("alu_wreg", 64'(wreg_o), 64'(wreg));
        check("alu_wdata", wdata_o, alu);
        check("alu_stall", 64'(stall_req_o), 64'd0);
        tick();
        check("alu_valid_drop", 64'(out_valid_o), 64'd0);
    endtask

    // rdy_dly: REQ cycles without ready; rv_dly: WAIT cycles without rvalid.
    // junk: drive ignored ex ops while busy and a bogus rvalid alongside ready.
    task automatic do_mem(input logic ld, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] sdata, input logic [63:0] rdata,
                          input logic [4:0] wd, input logic wreg,
                          input int rdy_dly, input int rv_dly, input logic junk,
                          input logic [63:0] exp_addr, input logic [7:0] exp_mask,
                          input logic [63:0] exp_wdata, input logic [63:0] exp_res,
                          output int nonidle);
        nonidle = 0;
        drive_ex(ld, !ld, f3, addr, sdata, wd, wreg, 64'h5A5A);
        tick();
        ex_valid_i = junk;
        for (int c = 0; c <= rdy_dly; c++) begin
            check("req_high", 64'(dmem_req_o), 64'd1);
            check("req_addr", dmem_addr_o, exp_addr);
            check("req_we", 64'(dmem_we_o), 64'(!ld));
            if (!ld) begin
                check("req_wmask", 64'(dmem_wmask_o), 64'(exp_mask));
                check("req_wdata", dmem_wdata_o, exp_wdata);
            end
            check("req_stall", 64'(stall_req_o), 64'd1);
            check("req_no_valid", 64'(out_valid_o), 64'd0);
            nonidle++;
            dmem_ready_i = (c == rdy_dly);
            if (junk && ld && c == rdy_dly) begin
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = ~rdata;
            end
            tick();
            dmem_ready_i  = 1'b0;
            dmem_rvalid_i = 1'b0;
        end
        if (!ld) begin
            ex_valid_i = 1'b0;
            check("st_done_valid", 64'(out_valid_o), 64'd1);
            check("st_done_wreg", 64'(wreg_o), 64'd0);
            check("st_done_stall", 64'(stall_req_o), 64'd0);
        end else begin
            for (int c = 0; c <= rv_dly; c++) begin
                check("wait_req_low", 64'(dmem_req_o), 64'd0);
                check("wait_stall", 64'(stall_req_o), 64'd1);
                check("wait_no_valid", 64'(out_valid_o), 64'd0);
                nonidle++;
                if (c == rv_dly) begin
                    dmem_rvalid_i = 1'b1;
                    dmem_rdata_i  = rdata;
                end
                tick();
                dmem_rvalid_i = 1'b0;
            end
            ex_valid_i = 1'b0;
            check("ld_valid", 64'(out_valid_o), 64'd1);
            check("ld_wd", 64'(wd_o), 64'(wd));
            check("ld_wreg", 64'(wreg_o), 64'(wreg));
            check("ld_wdata", wdata_o, exp_res);
            check("ld_stall", 64'(stall_req_o), 64'd0);
        end
        tick();
        check("post_valid", 64'(out_valid_o), 64'd0);
        check("post_wdata", wdata_o, 64'd0);
    endtask

    task automatic do_trap(input logic ld, input logic [2:0] f3, input logic [63:0] addr);
        drive_ex(ld, !ld, f3, addr, 64'h1, 5'd3, 1'b1, 64'd0);
        tick();
        ex_valid_i = 1'b0;
        check("trap_misalign", 64'(misalign_o), 64'd1);
        check("trap_valid", 64'(out_valid_o), 64'd1);
        check("trap_wreg", 64'(wreg_o), 64'd0);
        check("trap_req", 64'(dmem_req_o), 64'd0);
        check("trap_stall", 64'(stall_req_o), 64'd0);
        tick();
        check("trap_misalign_drop", 64'(misalign_o), 64'd0);
        check("trap_req_after", 64'(dmem_req_o), 64'd0);
    endtask

    typedef struct {
        logic [1:0]  kind;   // 0 alu, 1 load, 2 store
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] rdata;
        logic [4:0]  wd;
        logic        wreg;
        logic [63:0] alu;
        logic [63:0] exp_addr;
        logic [7:0]  exp_mask;
        logic [63:0] exp_wdata;
        logic [63:0] exp_res;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int n;
        rst_n = 1'b1;
        ex_valid_i = 1'b0; ex_wd_i = '0; ex_wreg_i = 1'b0; ex_wdata_i = '0;
        ex_is_load_i = 1'b0; ex_is_store_i = 1'b0; ex_funct3_i = '0;
        ex_addr_i = '0; ex_sdata_i = '0;
        dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;

        vecs[0]  = '{0, F3_B,  64'h0,    64'h0, 64'h0, 5'd5, 1'b1, 64'h1234, 64'h0, 8'h00, 64'h0, 64'h1234};
        vecs[1]  = '{1, F3_B,  64'h1003, 64'h0, 64'h00000000_80000000, 5'd9, 1'b1, 64'h0, 64'h1000, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFFF80};
        vecs[2]  = '{1, F3_BU, 64'h1003, 64'h0, 64'h00000000_80000000, 5'd9, 1'b1, 64'h0, 64'h1000, 8'h00, 64'h0, 64'h80};
        vecs[3]  = '{2, F3_H,  64'h2006, 64'hBEEF, 64'h0, 5'd4, 1'b1, 64'h0, 64'h2000, 8'hC0, 64'hBEEF0000_00000000, 64'h0};
        vecs[4]  = '{1, F3_W,  64'h1004, 64'h0, 64'h87654321_00000000, 5'd10, 1'b1, 64'h0, 64'h1000, 8'h00, 64'h0, 64'hFFFFFFFF_87654321};
        vecs[5]  = '{1, F3_WU, 64'h1004, 64'h0, 64'h87654321_00000000, 5'd11, 1'b1, 64'h0, 64'h1000, 8'h00, 64'h0, 64'h00000000_87654321};
        vecs[6]  = '{1, F3_D,  64'h3000, 64'h0, 64'h01234567_89ABCDEF, 5'd12, 1'b1, 64'h0, 64'h3000, 8'h00, 64'h0, 64'h01234567_89ABCDEF};
        vecs[7]  = '{2, F3_D,  64'h3008, 64'hCAFEF00D_12345678, 64'h0, 5'd1, 1'b1, 64'h0, 64'h3008, 8'hFF, 64'hCAFEF00D_12345678, 64'h0};
        vecs[8]  = '{2, F3_B,  64'h4005, 64'hAB, 64'h0, 5'd1, 1'b1, 64'h0, 64'h4000, 8'h20, 64'h0000AB00_00000000, 64'h0};
        vecs[9]  = '{1, F3_H,  64'h5002, 64'h0, 64'h00000000_7FFF0000, 5'd13, 1'b0, 64'h0, 64'h5000, 8'h00, 64'h0, 64'h7FFF};
        vecs[10] = '{1, F3_HU, 64'h5006, 64'h0, 64'hFFEE0000_00000000, 5'd14, 1'b1, 64'h0, 64'h5000, 8'h00, 64'h0, 64'hFFEE};
        vecs[11] = '{2, F3_W,  64'h6004, 64'h11223344, 64'h0, 5'd1, 1'b1, 64'h0, 64'h6000, 8'hF0, 64'h11223344_00000000, 64'h0};
        vecs[12] = '{0, F3_B,  64'h0,    64'h0, 64'h0, 5'd7, 1'b0, 64'hDEAD, 64'h0, 8'h00, 64'h0, 64'hDEAD};

        // reset values
        tick();
        tick();
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_wd", 64'(wd_o), 64'd0);
        check("rst_wreg", 64'(wreg_o), 64'd0);
        check("rst_wdata", wdata_o, 64'd0);
        check("rst_req", 64'(dmem_req_o), 64'd0);
        check("rst_we", 64'(dmem_we_o), 64'd0);
        check("rst_addr", dmem_addr_o, 64'd0);
        check("rst_dwdata", dmem_wdata_o, 64'd0);
        check("rst_wmask", 64'(dmem_wmask_o), 64'd0);
        check("rst_misalign", 64'(misalign_o), 64'd0);
        check("rst_stall", 64'(stall_req_o), 64'd0);
        check("rst_state", 64'(dbg_state_o), 64'(ST_IDLE));
        rst_n = 1'b0;
        tick();

        // directed table, immediate ready/rvalid
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].kind == 2'd0) begin
                do_alu(vecs[i].wd, vecs[i].wreg, vecs[i].alu);
            end else begin
                do_mem(vecs[i].kind == 2'd1, vecs[i].f3, vecs[i].addr, vecs[i].sdata,
                       vecs[i].rdata, vecs[i].wd, vecs[i].wreg, 0, 0, 1'b0,
                       vecs[i].exp_addr, vecs[i].exp_mask, vecs[i].exp_wdata,
                       vecs[i].exp_res, n);
                check("tbl_latency", 64'(n), (vecs[i].kind == 2'd1) ? 64'd2 : 64'd1);
            end
        end

        // LD: ready three cycles late, rvalid two cycles after ready -> 6 busy cycles
        do_mem(1'b1, F3_D, 64'h7008, 64'h0, 64'h0BAD_F00D_DEAD_BEEF, 5'd20, 1'b1, 3, 1, 1'b1,
               64'h7008, 8'h00, 64'h0, 64'h0BAD_F00D_DEAD_BEEF, n);
        check("ld_busy_cycles", 64'(n), 64'd6);

        // reset while in WAIT, then a late rvalid
        drive_ex(1'b1, 1'b0, F3_W, 64'h10, 64'h0, 5'd6, 1'b1, 64'h0);
        tick();
        ex_valid_i = 1'b0;
        dmem_ready_i = 1'b1;
        tick();
        dmem_ready_i = 1'b0;
        check("wait_before_rst", 64'(dbg_state_o), 64'(ST_WAIT));
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        check("rst_wait_state", 64'(dbg_state_o), 64'(ST_IDLE));
        check("rst_wait_stall", 64'(stall_req_o), 64'd0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 64'h1234;
        tick();
        dmem_rvalid_i = 1'b0;
        check("late_rvalid_valid", 64'(out_valid_o), 64'd0);
        check("late_rvalid_state", 64'(dbg_state_o), 64'(ST_IDLE));
        tick();
        check("late_rvalid_valid2", 64'(out_valid_o), 64'd0);

        // reset while in REQ drops the request
        drive_ex(1'b0, 1'b1, F3_D, 64'h20, 64'h77, 5'd6, 1'b1, 64'h0);
        tick();
        ex_valid_i = 1'b0;
        check("req_before_rst", 64'(dmem_req_o), 64'd1);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        check("rst_req_drop", 64'(dmem_req_o), 64'd0);
        check("rst_req_valid", 64'(out_valid_o), 64'd0);
        tick();
        check("rst_req_valid2", 64'(out_valid_o), 64'd0);

`ifdef LSU_MISALIGN_TRAP_EN
        do_trap(1'b1, F3_W, 64'h1002);
`else
        // misaligned LW is aligned down to the word
        do_mem(1'b1, F3_W, 64'h1002, 64'h0, 64'hAAAA5555_80000001, 5'd2, 1'b1, 0, 0, 1'b0,
               64'h1000, 8'h00, 64'h0, 64'hFFFFFFFF_80000001, n);
`endif

        // random ops against the model
        for (int i = 0; i < 200; i++) begin
            logic [1:0]  kind;
            logic [2:0]  f3;
            logic [63:0] addr, sdata, rdata, alu;
            logic [4:0]  wd;
            logic        wreg;
            int          off;
            kind  = 2'($urandom_range(0, 2));
            addr  = {$urandom, $urandom};
            sdata = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            alu   = {$urandom, $urandom};
            wd    = 5'($urandom);
            wreg  = 1'($urandom);
            f3    = (kind == 2'd1) ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
            // idle gap with a stray rvalid that must be ignored
            dmem_rvalid_i = 1'($urandom);
            tick();
            dmem_rvalid_i = 1'b0;
            check("gap_valid", 64'(out_valid_o), 64'd0);
            if (kind == 2'd0) begin
                do_alu(wd, wreg, alu);
            end else begin
`ifdef LSU_MISALIGN_TRAP_EN
                if (m_misaligned(addr, f3)) begin
                    do_trap(kind == 2'd1, f3, addr);
                    continue;
                end
                off = int'(addr % 64'd8);
`else
                off = m_off(addr, f3);
`endif
                do_mem(kind == 2'd1, f3, addr, sdata, rdata, wd, wreg,
                       $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                       addr & ~64'd7, m_mask(f3, off), m_store(sdata, off),
                       m_load(rdata, f3, off), n);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard bound on runtime
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu_access.md
# lsu_access

Load/store access unit between the execute stage and the memory stage. It registers the execute result and drives the data-memory bus for loads and stores. It then returns the write-back triple (`wd`, `wreg`, `wdata`) that the memory stage forwards to write-back. While a bus transaction is outstanding it holds the pipeline through `stall_req_o`.

## Interface
- `XLEN`, 64, register and data width (matches `RegBus`)
- `clk` input 1: rising-edge clock
- `rst_n` input 1: reset; synchronous, active-high (asserted = 1, sampled on `clk`)
- `ex_valid_i` input 1: execute stage presents an instruction this cycle
- `ex_wd_i` input 5: destination register address
- `ex_wreg_i` input 1: destination write enable
- `ex_wdata_i` input XLEN: ALU result (used for non-memory ops)
- `ex_is_load_i` / `ex_is_store_i` input 1 each: memory op class (never both)
- `ex_funct3_i` input 3: size/sign (LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110; stores 000–011)
- `ex_addr_i` input XLEN: effective address
- `ex_sdata_i` input XLEN: store data
- `stall_req_o` output 1: hold execute and earlier stages
- `dmem_req_o` output 1: bus request
- `dmem_we_o` output 1: 1 = store
- `dmem_addr_o` output XLEN: address with bits [2:0] = 0
- `dmem_wdata_o` output XLEN: lane-shifted store data
- `dmem_wmask_o` output 8: byte strobes
- `dmem_ready_i` input 1: request accepted this cycle
- `dmem_rvalid_i` input 1: read data valid
- `dmem_rdata_i` input XLEN: read data (whole aligned doubleword)
- `out_valid_o` output 1: one-cycle pulse; result valid
- `wd_o` output 5, `wreg_o` output 1, `wdata_o` output XLEN: to memory stage
- `misalign_o` output 1: misaligned-access pulse (see Configuration)

## Operation
- FSM states are IDLE, REQ and WAIT. Inputs are accepted only in IDLE with `ex_valid_i=1`.
- Non-memory op, accepted in IDLE:
  - Register `wd`/`wreg`/`wdata` and pulse `out_valid_o` next cycle.
  - Stay in IDLE.
- Load or store, accepted in IDLE:
  - Latch the op fields and go to REQ.
- REQ:
  - `dmem_req_o=1`. Addr, we, wdata and wmask are held stable until `dmem_ready_i`.
  - Store with ready: go to IDLE. Next cycle pulse `out_valid_o` with `wreg_o=0`.
  - Load with ready: go to WAIT.
- WAIT:
  - `dmem_req_o=0`.
  - On `dmem_rvalid_i`, compute the result, register it with the latched `wd`/`wreg`, pulse `out_valid_o` next cycle, and go to IDLE.
- `stall_req_o = (state != IDLE)`. It is combinational from the state register.
- Lane rules, with offset = `addr[2:0]`:
  - Byte mask: SB = 0x01, SH = 0x03, SW = 0x0F, SD = 0xFF, each shifted left by offset.
  - Store data: `ex_sdata_i` shifted left by offset·8.
  - Load data: `dmem_rdata_i` shifted right by offset·8, truncated to size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to XLEN.
- Outputs when `out_valid_o=0`: `wd_o=0`, `wreg_o=0`, `wdata_o=0`.
- `dmem_rvalid_i` outside WAIT is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - `out_valid_o`, `wd_o`, `wreg_o`, `wdata_o`, `dmem_req_o`, `dmem_we_o`, `dmem_addr_o`, `dmem_wdata_o`, `dmem_wmask_o`, `misalign_o` are all 0.
  - `stall_req_o` = 0.
- Latency:
  - ALU op accepted at cycle N: result at N+1.
  - Load accepted at N, ready at N+1, rvalid at N+2: result at N+3.
  - Store accepted at N, ready at N+1: completion pulse at N+2.
- Back-pressure: each extra cycle without ready (in REQ) or without rvalid (in WAIT) adds one cycle.
- Reset during REQ or WAIT:
  - Return to IDLE next edge and drop the request.
  - A late `dmem_rvalid_i` after reset is ignored.
  - No `out_valid_o` pulse for the aborted op.
- Ready and rvalid in the same cycle in REQ: rvalid is ignored, and the load waits for a later rvalid in WAIT.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - An access is misaligned when `addr` is not a multiple of its size.
  - A misaligned access is not issued. The FSM stays in IDLE.
  - Next cycle: `misalign_o` and `out_valid_o` pulse together with `wreg_o=0`.
- Undefined:
  - `misalign_o` is tied to 0.
  - The offset is forced down to natural alignment: clear the low log2(size) bits of offset, then issue normally.

## Structure
- Constants go in `defines.v`:
  - FSM state encodings.
  - funct3 size codes.
  - `ZeroWord`, `NOPRegAddr`, `WriteDisable`.
- One combinational sub-module, `lsu_align`: computes the mask and store shift from funct3/offset, and performs the load shift and extension.

## Test plan
- ALU op: `ex_wd_i=5`, `ex_wdata_i=0x1234`, `ex_wreg_i=1` → next cycle `out_valid_o=1`, `wd_o=5`, `wdata_o=0x1234`; `stall_req_o` stays 0.
- LB at addr 0x1003 with rdata 0x00000000_80000000 and ready/rvalid immediate → `dmem_addr_o=0x1000`; result at N+3 is `wdata_o=0xFFFFFFFF_FFFFFF80`; LBU at the same address gives 0x80.
- SH at 0x2006 with sdata 0xBEEF → `dmem_wmask_o=0xC0`, `dmem_wdata_o[63:48]=0xBEEF`; completion pulse has `wreg_o=0`.
- LD with ready delayed 3 cycles and rvalid delayed 2 more → request fields stable throughout; `stall_req_o=1` for all 6 non-IDLE cycles; one result pulse.
- Reset asserted in WAIT, then rvalid → no `out_valid_o` pulse; state is IDLE.
- With `LSU_MISALIGN_TRAP_EN`: LW at 0x1002 → `dmem_req_o` never asserts; `misalign_o` pulses once.
